// File: rtl/pueo_turf_trig_arbiter.sv
// Trigger arbiter: collects soft/PPS/ext requests into one-deep pending flags
// and issues them on trigger slots with fixed priority and a slot holdoff.
module pueo_turf_trig_arbiter #(
    parameter SYSCLKTYPE = "NONE",
    parameter int HOLDOFF_WIDTH = 16
) (
    input  logic                     sysclk_i,
    input  logic                     rst_i,
    input  logic                     trig_ce_i,
    input  logic                     running_i,
    input  logic [11:0]              cur_addr_i,
    input  logic [2:0]               src_enable_i,
    input  logic [HOLDOFF_WIDTH-1:0] holdoff_i,
    input  logic                     soft_req_i,
    input  logic                     pps_req_i,
    input  logic                     ext_req_i,
    input  logic [5:0]               soft_meta_i,
    output logic [11:0]              turf_trig_o,
    output logic [7:0]               turf_metadata_o,
    output logic                     turf_valid_o,
    output logic [31:0]              issue_count_o,
    output logic [15:0]              drop_count_o,
    output logic                     busy_o
);

    typedef enum logic {IDLE, HOLDOFF} state_t;

    state_t                   state_reg, state_next;
    logic [HOLDOFF_WIDTH-1:0] hold_cnt_reg, hold_cnt_next;
    logic [2:0]               req, pend_reg, active, winner, clr, drop;
    logic [5:0]               soft_meta_reg;
    logic                     issue;
    logic [1:0]               code;
    logic [1:0]               n_drop;
    logic [16:0]              drop_sum;
    logic [11:0]              trig_reg;
    logic [7:0]               meta_reg;
    logic                     valid_reg;
    logic [31:0]              issue_count_reg;
    logic [15:0]              drop_count_reg;

    // The clock-type string is an annotation for downstream tooling only.
    if (SYSCLKTYPE == "NONE") begin : g_sysclk_plain
    end else begin : g_sysclk_annotated
    end

    // Bit order everywhere: [0] soft, [1] PPS, [2] ext.
    assign req    = {ext_req_i, pps_req_i, soft_req_i};
    assign active = pend_reg & src_enable_i;
    assign clr    = issue ? winner : 3'b000;

    // Fixed priority select of the issuing source: ext > PPS > soft.
    always_comb begin
        winner = 3'b000;
        code   = 2'd1;
        if (active[2]) begin
            winner = 3'b100;
            code   = 2'd3;
        end else if (active[1]) begin
            winner = 3'b010;
            code   = 2'd2;
        end else if (active[0]) begin
            winner = 3'b001;
            code   = 2'd1;
        end
    end

    // Next-state logic: issue from IDLE, count holdoff slots in HOLDOFF.
    always_comb begin
        state_next    = state_reg;
        hold_cnt_next = hold_cnt_reg;
        issue         = 1'b0;
        if (!running_i) begin
            state_next    = IDLE;
            hold_cnt_next = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (trig_ce_i && (active != 3'b000)) begin
                        issue = 1'b1;
                        if (holdoff_i != '0) begin
                            state_next    = HOLDOFF;
                            hold_cnt_next = holdoff_i;
                        end
                    end
                end
                HOLDOFF: begin
                    if (trig_ce_i) begin
                        if (hold_cnt_reg <= HOLDOFF_WIDTH'(1)) begin
                            state_next    = IDLE;
                            hold_cnt_next = '0;
                        end else begin
                            hold_cnt_next = hold_cnt_reg - HOLDOFF_WIDTH'(1);
                        end
                    end
                end
                default: begin
                    state_next    = IDLE;
                    hold_cnt_next = '0;
                end
            endcase
        end
    end

    // State and holdoff counter registers.
    always_ff @(posedge sysclk_i) begin
        if (rst_i) begin
            state_reg    <= IDLE;
            hold_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            hold_cnt_reg <= hold_cnt_next;
        end
    end

    // One-deep pending flag per source; a request re-arms even on its clear edge.
    for (genvar gi = 0; gi < 3; gi++) begin : g_pend
        assign drop[gi] = running_i && src_enable_i[gi] && req[gi]
                          && pend_reg[gi] && !clr[gi];

        // Pending flag update for this source.
        always_ff @(posedge sysclk_i) begin
            if (rst_i || !running_i || !src_enable_i[gi]) begin
                pend_reg[gi] <= 1'b0;
            end else if (req[gi]) begin
                pend_reg[gi] <= 1'b1;
            end else if (clr[gi]) begin
                pend_reg[gi] <= 1'b0;
            end
        end
    end

    // Soft metadata is captured only when the request is accepted, not dropped.
    always_ff @(posedge sysclk_i) begin
        if (rst_i) begin
            soft_meta_reg <= '0;
        end else if (running_i && src_enable_i[0] && soft_req_i && !drop[0]) begin
            soft_meta_reg <= soft_meta_i;
        end
    end

    // Up to three drops can land in one cycle; the sum saturates at 0xFFFF.
    assign n_drop   = {1'b0, drop[0]} + {1'b0, drop[1]} + {1'b0, drop[2]};
    assign drop_sum = {1'b0, drop_count_reg} + {15'b0, n_drop};

    // Issue outputs and statistics counters.
    always_ff @(posedge sysclk_i) begin
        if (rst_i) begin
            valid_reg       <= 1'b0;
            trig_reg        <= '0;
            meta_reg        <= '0;
            issue_count_reg <= '0;
            drop_count_reg  <= '0;
        end else begin
            valid_reg <= issue;
            if (issue) begin
                trig_reg        <= cur_addr_i;
                meta_reg        <= {code, (winner[0] ? soft_meta_reg : 6'd0)};
                issue_count_reg <= issue_count_reg + 32'd1;
            end
            drop_count_reg <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

    assign turf_valid_o    = valid_reg;
    assign turf_trig_o     = trig_reg;
    assign turf_metadata_o = meta_reg;
    assign issue_count_o   = issue_count_reg;
    assign drop_count_o    = drop_count_reg;
    assign busy_o          = (state_reg == HOLDOFF) || (active != 3'b000);

endmodule

// File: tb/tb_pueo_turf_trig_arbiter.sv
// Directed table-driven bench for pueo_turf_trig_arbiter.
module tb_pueo_turf_trig_arbiter;

    logic        sysclk_i = 1'b0;
    logic        rst_i;
    logic        trig_ce_i;
    logic        running_i;
    logic [11:0] cur_addr_i;
    logic [2:0]  src_enable_i;
    logic [15:0] holdoff_i;
    logic        soft_req_i, pps_req_i, ext_req_i;
    logic [5:0]  soft_meta_i;
    logic [11:0] turf_trig_o;
    logic [7:0]  turf_metadata_o;
    logic        turf_valid_o;
    logic [31:0] issue_count_o;
    logic [15:0] drop_count_o;
    logic        busy_o;

    int n_cmp = 0;
    int n_bad = 0;

    pueo_turf_trig_arbiter #(.SYSCLKTYPE("NONE"), .HOLDOFF_WIDTH(16)) dut (
        .sysclk_i(sysclk_i), .rst_i(rst_i), .trig_ce_i(trig_ce_i),
        .running_i(running_i), .cur_addr_i(cur_addr_i), .src_enable_i(src_enable_i),
        .holdoff_i(holdoff_i), .soft_req_i(soft_req_i), .pps_req_i(pps_req_i),
        .ext_req_i(ext_req_i), .soft_meta_i(soft_meta_i), .turf_trig_o(turf_trig_o),
        .turf_metadata_o(turf_metadata_o), .turf_valid_o(turf_valid_o),
        .issue_count_o(issue_count_o), .drop_count_o(drop_count_o), .busy_o(busy_o)
    );

    always #5 sysclk_i = ~sysclk_i;

    typedef struct {
        logic        ce, run;
        logic [2:0]  en;
        logic [15:0] hold;
        logic [11:0] addr;
        logic        s, p, e;
        logic [5:0]  meta;
        logic        v;
        logic [11:0] trig;
        logic [7:0]  md;
        logic [31:0] ic;
        logic [15:0] dc;
        logic        busy;
    } vec_t;

    vec_t vecs[31];

    function automatic vec_t mk(input logic ce, input logic run, input logic [2:0] en,
                                input logic [15:0] hold, input logic [11:0] addr,
                                input logic s, input logic p, input logic e,
                                input logic [5:0] meta, input logic v,
                                input logic [11:0] trig, input logic [7:0] md,
                                input logic [31:0] ic, input logic [15:0] dc,
                                input logic busy);
        vec_t r;
        r.ce = ce; r.run = run; r.en = en; r.hold = hold; r.addr = addr;
        r.s = s; r.p = p; r.e = e; r.meta = meta; r.v = v; r.trig = trig;
        r.md = md; r.ic = ic; r.dc = dc; r.busy = busy;
        return r;
    endfunction

    function automatic logic [69:0] outs();
        return {turf_valid_o, turf_trig_o, turf_metadata_o, issue_count_o,
                drop_count_o, busy_o};
    endfunction

    task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got v/trig/md/ic/dc/busy=%h required %h", name, act, exp);
        end else begin
            $display("ok   %s: v/trig/md/ic/dc/busy=%h", name, act);
        end
    endtask

    task automatic drive(input logic ce, input logic run, input logic [2:0] en,
                         input logic [15:0] hold, input logic [11:0] addr,
                         input logic s, input logic p, input logic e,
                         input logic [5:0] meta);
        trig_ce_i = ce; running_i = run; src_enable_i = en; holdoff_i = hold;
        cur_addr_i = addr; soft_req_i = s; pps_req_i = p; ext_req_i = e;
        soft_meta_i = meta;
    endtask

    task automatic tick();
        @(posedge sysclk_i);
        #1;
    endtask

    initial begin
        // Table: inputs for one cycle, then outputs expected after that edge.
        vecs[0]  = mk(0,1,3'b001,0,12'h123,1,0,0,6'h15, 0,12'h000,8'h00,0,0,1);
        vecs[1]  = mk(1,1,3'b001,0,12'h123,0,0,0,6'h00, 1,12'h123,8'h55,1,0,0);
        vecs[2]  = mk(0,1,3'b001,0,12'h123,0,0,0,6'h00, 0,12'h123,8'h55,1,0,0);
        vecs[3]  = mk(0,1,3'b111,0,12'h200,1,1,1,6'h2A, 0,12'h123,8'h55,1,0,1);
        vecs[4]  = mk(1,1,3'b111,0,12'h200,0,0,0,6'h00, 1,12'h200,8'hC0,2,0,1);
        vecs[5]  = mk(1,1,3'b111,0,12'h201,0,0,0,6'h00, 1,12'h201,8'h80,3,0,1);
        vecs[6]  = mk(1,1,3'b111,0,12'h202,0,0,0,6'h00, 1,12'h202,8'h6A,4,0,0);
        vecs[7]  = mk(0,1,3'b111,0,12'h203,0,0,0,6'h00, 0,12'h202,8'h6A,4,0,0);
        vecs[8]  = mk(0,1,3'b111,0,12'h300,1,0,0,6'h01, 0,12'h202,8'h6A,4,0,1);
        vecs[9]  = mk(0,1,3'b111,0,12'h300,1,0,0,6'h02, 0,12'h202,8'h6A,4,1,1);
        vecs[10] = mk(0,1,3'b111,0,12'h300,1,0,0,6'h03, 0,12'h202,8'h6A,4,2,1);
        vecs[11] = mk(1,1,3'b111,0,12'h300,0,0,0,6'h00, 1,12'h300,8'h41,5,2,0);
        vecs[12] = mk(0,1,3'b111,0,12'h310,1,0,0,6'h05, 0,12'h300,8'h41,5,2,1);
        vecs[13] = mk(1,1,3'b111,0,12'h310,1,0,0,6'h06, 1,12'h310,8'h45,6,2,1);
        vecs[14] = mk(1,1,3'b111,0,12'h311,0,0,0,6'h00, 1,12'h311,8'h46,7,2,0);
        vecs[15] = mk(0,1,3'b111,3,12'h400,1,0,0,6'h0A, 0,12'h311,8'h46,7,2,1);
        vecs[16] = mk(1,1,3'b111,3,12'h400,1,0,0,6'h0B, 1,12'h400,8'h4A,8,2,1);
        vecs[17] = mk(0,1,3'b111,3,12'h401,0,0,0,6'h00, 0,12'h400,8'h4A,8,2,1);
        vecs[18] = mk(1,1,3'b111,3,12'h401,0,0,0,6'h00, 0,12'h400,8'h4A,8,2,1);
        vecs[19] = mk(1,1,3'b111,3,12'h402,0,0,0,6'h00, 0,12'h400,8'h4A,8,2,1);
        vecs[20] = mk(1,1,3'b111,3,12'h403,0,0,0,6'h00, 0,12'h400,8'h4A,8,2,1);
        vecs[21] = mk(1,1,3'b111,3,12'h404,0,0,0,6'h00, 1,12'h404,8'h4B,9,2,1);
        vecs[22] = mk(1,0,3'b111,3,12'h405,0,0,1,6'h00, 0,12'h404,8'h4B,9,2,0);
        vecs[23] = mk(0,1,3'b111,0,12'h405,0,1,0,6'h00, 0,12'h404,8'h4B,9,2,1);
        vecs[24] = mk(1,0,3'b111,0,12'h406,0,0,0,6'h00, 0,12'h404,8'h4B,9,2,0);
        vecs[25] = mk(1,1,3'b111,0,12'h407,0,0,0,6'h00, 0,12'h404,8'h4B,9,2,0);
        vecs[26] = mk(0,1,3'b001,0,12'h408,0,0,1,6'h00, 0,12'h404,8'h4B,9,2,0);
        vecs[27] = mk(1,1,3'b001,0,12'h408,0,0,0,6'h00, 0,12'h404,8'h4B,9,2,0);
        vecs[28] = mk(0,1,3'b111,0,12'h409,1,0,0,6'h11, 0,12'h404,8'h4B,9,2,1);
        vecs[29] = mk(0,1,3'b110,0,12'h409,0,0,0,6'h00, 0,12'h404,8'h4B,9,2,0);
        vecs[30] = mk(1,1,3'b111,0,12'h409,0,0,0,6'h00, 0,12'h404,8'h4B,9,2,0);

        // Reset state.
        rst_i = 1'b1;
        drive(0,1,3'b111,0,12'h000,0,0,0,6'h00);
        tick();
        tick();
        check("reset", outs(), 70'd0);
        rst_i = 1'b0;

        // Table-driven vectors.
        for (int i = 0; i < 31; i++) begin
            drive(vecs[i].ce, vecs[i].run, vecs[i].en, vecs[i].hold, vecs[i].addr,
                  vecs[i].s, vecs[i].p, vecs[i].e, vecs[i].meta);
            tick();
            check($sformatf("vec%0d", i), outs(),
                  {vecs[i].v, vecs[i].trig, vecs[i].md, vecs[i].ic, vecs[i].dc, vecs[i].busy});
        end

        // Reset in the middle of a holdoff with a request pending.
        drive(0,1,3'b111,5,12'h500,1,0,0,6'h07);
        tick();
        check("rst_seq_pend", outs(), {1'b0,12'h404,8'h4B,32'd9,16'd2,1'b1});
        drive(1,1,3'b111,5,12'h500,1,0,0,6'h08);
        tick();
        check("rst_seq_issue", outs(), {1'b1,12'h500,8'h47,32'd10,16'd2,1'b1});
        drive(1,1,3'b111,5,12'h501,0,0,0,6'h00);
        tick();
        check("rst_seq_hold", outs(), {1'b0,12'h500,8'h47,32'd10,16'd2,1'b1});
        rst_i = 1'b1;
        drive(1,1,3'b111,0,12'h502,1,1,1,6'h3F);
        tick();
        check("rst_seq_reset", outs(), 70'd0);
        rst_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1,1,3'b111,0,12'h503,0,0,0,6'h00);
            tick();
            check($sformatf("post_rst%0d", i), outs(), 70'd0);
        end

        // Drop counter saturation: all three sources pending, re-requested every cycle.
        drive(0,1,3'b111,0,12'h600,1,1,1,6'h00);
        tick();
        for (int i = 0; i < 21844; i++) tick();
        check("drop_65532", {54'd0, drop_count_o}, {54'd0, 16'd65532});
        tick();
        check("drop_65535", {54'd0, drop_count_o}, {54'd0, 16'hFFFF});
        tick();
        check("drop_sat", {54'd0, drop_count_o}, {54'd0, 16'hFFFF});
        drive(0,1,3'b111,0,12'h600,0,0,0,6'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
